// File: rtl/alarm_ringer.sv
// Alarm ringer: detects the rising edge of a live-time/alarm-time match and
// runs the ring / snooze / stop sequence that drives the buzzer and LEDs.
module alarm_ringer #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned SNOOZE_MAX  = 3,
  parameter int unsigned CW          = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       en,
  input  logic       adj_active,
  input  logic [3:0] HT,
  input  logic [3:0] HU,
  input  logic [3:0] MT,
  input  logic [3:0] MU,
  input  logic [3:0] HT_al,
  input  logic [3:0] HU_al,
  input  logic [3:0] MT_al,
  input  logic [3:0] MU_al,
  input  logic       bt_stop,
  input  logic       bt_snooze,
  output logic       buzzer,
  output logic [3:0] leds,
  output logic       ringing,
  output logic [1:0] snooze_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RING   = 2'd1;
  localparam logic [1:0] S_SNOOZE = 2'd2;

  localparam logic [CW-1:0] RING_TERM   = CW'(RING_SECS);
  localparam logic [CW-1:0] SNOOZE_TERM = CW'(SNOOZE_SECS);
  localparam logic [1:0]    SNZ_LIMIT   = 2'(SNOOZE_MAX);

  logic [1:0]    r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_snz, w_snz;
  logic          r_blink, w_blink;
  logic          r_match_q;

  logic          w_match;
  logic          w_trigger;
  logic [CW-1:0] w_cnt_inc;
  logic          w_in_ring;

  // Plain nibble equality; no BCD validity check.
  assign w_match   = (HT == HT_al) && (HU == HU_al) && (MT == MT_al) && (MU == MU_al);
  assign w_trigger = w_match & ~r_match_q & en & ~adj_active;
  assign w_cnt_inc = r_cnt + CW'(1);

  // State, counter and blink registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_snz     <= 2'd0;
      r_blink   <= 1'b0;
      r_match_q <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_snz     <= w_snz;
      r_blink   <= w_blink;
      r_match_q <= w_match;
    end
  end

  // Next-state logic; disarm beats stop beats snooze beats tick/timeout.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_snz   = r_snz;
    w_blink = r_blink;
    if (!en) begin
      w_state = S_IDLE;
      w_cnt   = '0;
      w_blink = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            w_state = S_RING;
            w_cnt   = '0;
            w_snz   = 2'd0;
            w_blink = 1'b1;
          end
        end
        S_RING: begin
          if (bt_stop) begin
            w_state = S_IDLE;
            w_cnt   = '0;
            w_blink = 1'b0;
          end else if (bt_snooze) begin
            w_cnt   = '0;
            w_blink = 1'b0;
            if (r_snz < SNZ_LIMIT) begin
              w_state = S_SNOOZE;
              w_snz   = r_snz + 2'd1;
            end else begin
              w_state = S_IDLE;
            end
          end else if (tick_1hz) begin
            if (w_cnt_inc >= RING_TERM) begin
              w_state = S_IDLE;
              w_cnt   = '0;
              w_blink = 1'b0;
            end else begin
              w_cnt   = w_cnt_inc;
              w_blink = ~r_blink;
            end
          end
        end
        S_SNOOZE: begin
          w_blink = 1'b0;
          if (bt_stop) begin
            w_state = S_IDLE;
            w_cnt   = '0;
          end else if (tick_1hz) begin
            if (w_cnt_inc >= SNOOZE_TERM) begin
              w_state = S_RING;
              w_cnt   = '0;
              w_blink = 1'b1;
            end else begin
              w_cnt   = w_cnt_inc;
            end
          end
        end
        default: begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_blink = 1'b0;
        end
      endcase
    end
  end

  // Outputs decode registered state only.
  assign w_in_ring  = (r_state == S_RING);
  assign ringing    = w_in_ring;
  assign buzzer     = w_in_ring & r_blink;
  assign leds       = {4{w_in_ring & r_blink}};
  assign snooze_cnt = r_snz;

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_alarm_ringer;

  localparam int unsigned RING_SECS   = 60;
  localparam int unsigned SNOOZE_SECS = 300;
  localparam int unsigned SNOOZE_MAX  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz, en, adj_active, bt_stop, bt_snooze;
  logic [3:0] HT, HU, MT, MU, HT_al, HU_al, MT_al, MU_al;
  logic       buzzer, ringing;
  logic [3:0] leds;
  logic [1:0] snooze_cnt;

  int n_checks = 0;
  int n_err    = 0;

  alarm_ringer #(
    .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS), .SNOOZE_MAX(SNOOZE_MAX), .CW(9)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .en(en), .adj_active(adj_active),
    .HT(HT), .HU(HU), .MT(MT), .MU(MU),
    .HT_al(HT_al), .HU_al(HU_al), .MT_al(MT_al), .MU_al(MU_al),
    .bt_stop(bt_stop), .bt_snooze(bt_snooze),
    .buzzer(buzzer), .leds(leds), .ringing(ringing), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: an alarm event is a mode plus seconds elapsed in it.
  typedef enum int {M_IDLE, M_RING, M_SNOOZE} mode_t;
  mode_t m_mode;
  int    m_secs;
  int    m_snoozes;
  bit    m_prev_match;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_secs = 0; m_snoozes = 0; m_prev_match = 0;
    end else begin
      bit mt, fire;
      mt   = ({HT, HU, MT, MU} == {HT_al, HU_al, MT_al, MU_al});
      fire = mt && !m_prev_match && en && !adj_active;
      m_prev_match = mt;
      if (!en) begin
        m_mode = M_IDLE; m_secs = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (fire) begin m_mode = M_RING; m_secs = 0; m_snoozes = 0; end
          M_RING: begin
            if (bt_stop) m_mode = M_IDLE;
            else if (bt_snooze) begin
              if (m_snoozes < SNOOZE_MAX) begin
                m_mode = M_SNOOZE; m_snoozes++; m_secs = 0;
              end else m_mode = M_IDLE;
            end else if (tick_1hz) begin
              m_secs++;
              if (m_secs == RING_SECS) m_mode = M_IDLE;
            end
          end
          M_SNOOZE: begin
            if (bt_stop) m_mode = M_IDLE;
            else if (tick_1hz) begin
              m_secs++;
              if (m_secs == SNOOZE_SECS) begin m_mode = M_RING; m_secs = 0; end
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  // Buzzer is on during the even seconds of a ring (starts on, toggles per tick).
  always @(negedge clk) begin
    if (reset) begin
      bit ring_e, buzz_e;
      ring_e = (m_mode == M_RING);
      buzz_e = ring_e && (m_secs % 2 == 0);
      chk("ringing", 32'(ringing), 32'(ring_e));
      chk("buzzer", 32'(buzzer), 32'(buzz_e));
      chk("leds", 32'(leds), buzz_e ? 32'hF : 32'h0);
      if (m_mode != M_IDLE) chk("snooze_cnt", 32'(snooze_cnt), 32'(m_snoozes));
    end
  end

  task automatic set_time(input logic [15:0] v);
    {HT, HU, MT, MU} = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_1hz = 1'b1; @(negedge clk);
      tick_1hz = 1'b0; @(negedge clk);
    end
  endtask

  task automatic pulse_stop();
    bt_stop = 1'b1; @(negedge clk); bt_stop = 1'b0;
  endtask

  task automatic pulse_snooze();
    bt_snooze = 1'b1; @(negedge clk); bt_snooze = 1'b0;
  endtask

  // Leave the alarm minute and come back so the match rises again.
  task automatic rematch();
    set_time(16'h0731); step(2);
    set_time(16'h0730); step(1);
  endtask

  initial begin
    reset = 1'b0; tick_1hz = 0; en = 1; adj_active = 0; bt_stop = 0; bt_snooze = 0;
    {HT_al, HU_al, MT_al, MU_al} = 16'h0730;
    set_time(16'h0729);
    step(3);
    chk("rst_ringing", 32'(ringing), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_buzzer", 32'(buzzer), 32'h0);
    chk("rst_snooze_cnt", 32'(snooze_cnt), 32'h0);
    reset = 1'b1;
    step(3);
    chk("idle_ringing", 32'(ringing), 32'h0);

    // First ring and auto-stop after 60 ticks.
    set_time(16'h0730); step(1);
    chk("ring_start", 32'(ringing), 32'h1);
    chk("ring_buzz0", 32'(buzzer), 32'h1);
    chk("ring_leds0", 32'(leds), 32'hF);
    chk("ring_snz0", 32'(snooze_cnt), 32'h0);
    tick_n(1);
    chk("ring_buzz1", 32'(buzzer), 32'h0);
    tick_n(58);
    chk("ring_59_ringing", 32'(ringing), 32'h1);
    chk("ring_59_buzz", 32'(buzzer), 32'h0);
    tick_n(1);
    chk("autostop_ringing", 32'(ringing), 32'h0);
    chk("autostop_leds", 32'(leds), 32'h0);
    step(5);
    chk("hold_no_rering", 32'(ringing), 32'h0);

    // Three snoozes, then the fourth request stops.
    rematch();
    chk("rematch_ring", 32'(ringing), 32'h1);
    for (int s = 1; s <= 3; s++) begin
      pulse_snooze();
      chk("snooze_ringing", 32'(ringing), 32'h0);
      chk("snooze_buzz", 32'(buzzer), 32'h0);
      chk("snooze_cnt", 32'(snooze_cnt), 32'(s));
      tick_n(299);
      chk("snooze_299", 32'(ringing), 32'h0);
      tick_n(1);
      chk("rering", 32'(ringing), 32'h1);
      chk("rering_buzz", 32'(buzzer), 32'h1);
    end
    pulse_snooze();
    chk("4th_snooze_stops", 32'(ringing), 32'h0);
    tick_n(3);
    chk("4th_snooze_idle", 32'(ringing), 32'h0);

    // Stop while the minute still matches; no re-fire until the edge returns.
    rematch();
    pulse_stop();
    chk("stop_idle", 32'(ringing), 32'h0);
    step(4);
    chk("stop_hold", 32'(ringing), 32'h0);

    // Stop and tick together.
    rematch(); tick_n(3);
    bt_stop = 1'b1; tick_1hz = 1'b1; @(negedge clk); bt_stop = 1'b0; tick_1hz = 1'b0;
    chk("stop_tick_idle", 32'(ringing), 32'h0);

    // Snooze and the timeout tick together: snooze wins.
    rematch(); tick_n(59);
    bt_snooze = 1'b1; tick_1hz = 1'b1; @(negedge clk); bt_snooze = 1'b0; tick_1hz = 1'b0;
    chk("snooze_timeout_ringing", 32'(ringing), 32'h0);
    chk("snooze_timeout_cnt", 32'(snooze_cnt), 32'h1);
    en = 1'b0; step(1); en = 1'b1;
    tick_n(300);
    chk("disarm_snooze", 32'(ringing), 32'h0);

    // Disarm during ring.
    rematch();
    en = 1'b0; step(1);
    chk("disarm_ring", 32'(ringing), 32'h0);
    en = 1'b1;

    // Adjusting suppresses the trigger edge.
    adj_active = 1'b1; rematch(); step(1);
    chk("adj_no_ring", 32'(ringing), 32'h0);
    adj_active = 1'b0; step(2);
    chk("adj_edge_gone", 32'(ringing), 32'h0);

    // Asynchronous reset mid-snooze, released while still matching.
    rematch(); pulse_snooze(); tick_n(5);
    @(posedge clk); #2;
    reset = 1'b0; #1;
    chk("async_rst_ringing", 32'(ringing), 32'h0);
    chk("async_rst_snz", 32'(snooze_cnt), 32'h0);
    chk("async_rst_leds", 32'(leds), 32'h0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("post_rst_trigger", 32'(ringing), 32'h1);

    // Randomized phase.
    for (int c = 0; c < 20000; c++) begin
      int r;
      tick_1hz  = ($urandom_range(0, 1) == 0);
      bt_stop   = ($urandom_range(0, 1499) == 0);
      bt_snooze = ($urandom_range(0, 79) == 0);
      en        = ($urandom_range(0, 2999) != 0);
      if ($urandom_range(0, 49) == 0) adj_active = ~adj_active;
      if ($urandom_range(0, 1999) == 0) {HT_al, HU_al, MT_al, MU_al} = 16'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        r = $urandom_range(0, 3);
        case (r)
          0, 3:    set_time({HT_al, HU_al, MT_al, MU_al});
          1:       set_time({HT_al, HU_al, MT_al, MU_al ^ 4'h1});
          default: set_time(16'($urandom));
        endcase
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
